// File: rtl/oserdes_serializer_model_if.sv
// Parallel word handshake into the serializer: data word, its tristate control, valid/ready.
interface oserdes_serializer_model_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] DIN;
  logic                  DIN_VALID;
  logic                  DIN_READY;
  logic                  T_IN;

  modport master (
    output DIN,
    output DIN_VALID,
    output T_IN,
    input  DIN_READY
  );

  modport slave (
    input  DIN,
    input  DIN_VALID,
    input  T_IN,
    output DIN_READY
  );
endinterface

// File: rtl/oserdes_serializer_model.sv
// Parallel-to-serial transmitter: DATA_WIDTH-bit words in over valid/ready, one bit per CLK on OQ.
// A holding register behind the shift register keeps back-to-back words gap-free.
module oserdes_serializer_model #(
  parameter int         DATA_WIDTH   = 8,
  parameter logic       SRVAL_OQ     = 1'b0,
  parameter logic [7:0] IDLE_PATTERN = 8'h00
) (
  input  logic                     CLK,
  input  logic                     RST,
  oserdes_serializer_model_if.slave din_bus,
  output logic                     OQ,
  output logic                     TQ,
  output logic                     WORD_START,
  output logic                     UNDERFLOW
);
  if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_width
    $error("oserdes_serializer_model: DATA_WIDTH must be in 2..8");
  end

  localparam logic [2:0] LAST_CNT = 3'(DATA_WIDTH - 1);

  logic [2:0] cnt_r;
  logic [6:0] sh_r;
  logic [7:0] hold_r;
  logic       hold_t_r;
  logic       hold_full_r;

  logic       boundary_s;
  logic       ready_s;
  logic       accept_s;
  logic       load_idle_s;
  logic       src_t_s;
  logic [7:0] din_s;
  logic [7:0] src_s;

  assign boundary_s        = (cnt_r == LAST_CNT);
  assign ready_s           = !RST && (!hold_full_r || boundary_s);
  assign accept_s          = din_bus.DIN_VALID && ready_s;
  assign din_s             = 8'(din_bus.DIN);
  assign din_bus.DIN_READY = ready_s;

  // Word for the next boundary: a held word wins, then a word bypassing hold, else idle
  always_comb begin
    src_s       = 8'(IDLE_PATTERN[DATA_WIDTH-1:0]);
    src_t_s     = 1'b1;
    load_idle_s = 1'b0;
    if (hold_full_r) begin
      src_s   = hold_r;
      src_t_s = hold_t_r;
    end else if (accept_s) begin
      src_s   = din_s;
      src_t_s = din_bus.T_IN;
    end else begin
      load_idle_s = 1'b1;
    end
  end

  // Bit counter, shift/hold registers and the registered pin outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r       <= LAST_CNT;
      sh_r        <= 7'h00;
      hold_r      <= 8'h00;
      hold_t_r    <= 1'b1;
      hold_full_r <= 1'b0;
      OQ          <= SRVAL_OQ;
      TQ          <= 1'b1;
      WORD_START  <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else if (boundary_s) begin
      cnt_r      <= 3'd0;
      WORD_START <= 1'b1;
      UNDERFLOW  <= load_idle_s;
      sh_r       <= src_s[7:1];
      OQ         <= src_s[0];
      TQ         <= src_t_s;
      // hold is consumed here; it refills only if a word was accepted on top of a full hold
      if (hold_full_r && accept_s) begin
        hold_r      <= din_s;
        hold_t_r    <= din_bus.T_IN;
        hold_full_r <= 1'b1;
      end else begin
        hold_full_r <= 1'b0;
      end
    end else begin
      cnt_r      <= cnt_r + 3'd1;
      OQ         <= sh_r[0];
      sh_r       <= {1'b0, sh_r[6:1]};
      WORD_START <= 1'b0;
      UNDERFLOW  <= 1'b0;
      if (accept_s) begin
        hold_r      <= din_s;
        hold_t_r    <= din_bus.T_IN;
        hold_full_r <= 1'b1;
      end
    end
  end
endmodule
